// File: rtl/synth_pkg.sv
// Shared types and default sizes for the synth control slice.
package synth_pkg;

    // Default sizing used by synth_ctrl when no override is given.
    localparam int unsigned DEF_NUM_KEYS       = 13;
    localparam int unsigned DEF_NUM_OCTAVES    = 4;
    localparam int unsigned DEF_NUM_MODES      = 4;
    localparam int unsigned DEF_LOCKOUT_CYCLES = 1000;

    // Waveform selection presented to the oscillator.
    typedef enum logic [1:0] {
        SQUARE   = 2'd0,
        SAW      = 2'd1,
        TRIANGLE = 2'd2,
        SINE     = 2'd3
    } mode_t;

    // Key arbitration state.
    typedef enum logic {
        IDLE    = 1'b0,
        PLAYING = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/lockout_timer.sv
// Per-button lockout: accepts a pulse only while idle, then ignores the
// button for LOCKOUT_CYCLES cycles.
module lockout_timer #(
    parameter int unsigned LOCKOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    output logic accept_out
);

    localparam int unsigned CW = $clog2(LOCKOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // A pulse is taken on the same cycle the counter is (or has just become) zero.
    assign accept_out = pulse_in && (count == '0);

    // Load on an accepted pulse, otherwise count down to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (accept_out) begin
            count <= CW'(LOCKOUT_CYCLES);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/synth_ctrl.sv
// Control sequencer: octave/mode stepping with button lockout, last-pressed
// key arbitration, and a registered configuration plus change strobe.
module synth_ctrl
    import synth_pkg::*;
#(
    parameter int unsigned NUM_KEYS       = DEF_NUM_KEYS,
    parameter int unsigned NUM_OCTAVES    = DEF_NUM_OCTAVES,
    parameter int unsigned NUM_MODES      = DEF_NUM_MODES,
    parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           octave_pulse,
    input  logic                           mode_pulse,
    input  logic [NUM_KEYS-1:0]            keys,
    output logic [$clog2(NUM_OCTAVES)-1:0] octave,
    output logic [$clog2(NUM_MODES)-1:0]   mode,
    output logic [$clog2(NUM_KEYS)-1:0]    note,
    output logic                           note_valid,
    output logic                           cfg_update
);

    localparam int unsigned OW = $clog2(NUM_OCTAVES);
    localparam int unsigned MW = $clog2(NUM_MODES);
    localparam int unsigned NW = $clog2(NUM_KEYS);

    ctrl_state_t         state;
    ctrl_state_t         state_nx;
    logic [NUM_KEYS-1:0] keys_q;
    logic [NUM_KEYS-1:0] new_press;
    logic [NW-1:0]       note_nx;
    logic                valid_nx;
    logic [OW-1:0]       octave_nx;
    logic [MW-1:0]       mode_nx;
    logic                changed;
    logic                octave_accept;
    logic                mode_accept;

    // Lowest set bit index of a key vector (0 when empty).
    function automatic logic [NW-1:0] lowest(input logic [NUM_KEYS-1:0] v);
        logic [NW-1:0] r;
        r = '0;
        for (int unsigned i = NUM_KEYS; i > 0; i--) begin
            if (v[NW'(i - 1)]) r = NW'(i - 1);
        end
        return r;
    endfunction

    lockout_timer #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_octave_lock (
        .clk        (clk),
        .rst        (rst),
        .pulse_in   (octave_pulse),
        .accept_out (octave_accept)
    );

    lockout_timer #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_mode_lock (
        .clk        (clk),
        .rst        (rst),
        .pulse_in   (mode_pulse),
        .accept_out (mode_accept)
    );

    assign new_press = keys & ~keys_q;

    // Next configuration: button stepping with wrap, key arbitration, change detect.
    always_comb begin
        octave_nx = octave;
        mode_nx   = mode;
        state_nx  = state;
        note_nx   = note;

        if (octave_accept) begin
            octave_nx = (octave == OW'(NUM_OCTAVES - 1)) ? '0 : octave + 1'b1;
        end
        if (mode_accept) begin
            mode_nx = (mode == MW'(NUM_MODES - 1)) ? '0 : mode + 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (keys != '0) begin
                    state_nx = PLAYING;
                    // A key held through reset has no press edge; take it from the level.
                    note_nx  = (new_press != '0) ? lowest(new_press) : lowest(keys);
                end
            end
            PLAYING: begin
                if (keys == '0) begin
                    state_nx = IDLE;
                end else if (new_press != '0) begin
                    note_nx = lowest(new_press);
                end else if (!keys[note]) begin
                    note_nx = lowest(keys);
                end
            end
            default: state_nx = IDLE;
        endcase

        valid_nx = (state_nx == PLAYING);
        changed  = (octave_nx != octave) || (mode_nx != mode) ||
                   (note_nx != note) || (valid_nx != note_valid);
    end

    // Register state, configuration outputs and the change strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            keys_q     <= '0;
            octave     <= '0;
            mode       <= MW'(SQUARE);
            note       <= '0;
            note_valid <= 1'b0;
            cfg_update <= 1'b0;
        end else begin
            state      <= state_nx;
            keys_q     <= keys;
            octave     <= octave_nx;
            mode       <= mode_nx;
            note       <= note_nx;
            note_valid <= valid_nx;
            cfg_update <= changed;
        end
    end

endmodule
